// File: rtl/freq_meas_pkg.sv
// ---------------------------------------------------------------------------
// freq_meas_pkg
// Shared definitions for the round-robin period measurement block:
//   - state_t     : scheduler state encoding (IDLE/ARM/MEASURE/STORE)
//   - DEF_*       : default channel count, result width and edge timeout
//   - ch_idx_w()  : width of a channel index for a given channel count
// ---------------------------------------------------------------------------
package freq_meas_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2,
      ST_STORE   = 2'd3
   } state_t;

   localparam int DEF_NCH     = 4;
   localparam int DEF_CW      = 16;
   localparam int DEF_TIMEOUT = 50000;

   // Width needed to hold a channel index 0..n-1 (never less than one bit).
   function automatic int ch_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/freq_sync_edge.sv
// ---------------------------------------------------------------------------
// freq_sync_edge
// Three-flop synchronizer for one asynchronous feedback pin plus a
// rising-edge detector on the two settled flops. The edge pulse is one clk
// wide and lags the pin by 2-3 clk cycles.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset, clears the shift register
//   i_sig   in   asynchronous input pin
//   o_rise  out  one-cycle pulse on a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module freq_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_sig,
   output logic o_rise
);

   logic [2:0] r_sr;

   // Shift the pin through the synchronizer chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sr <= 3'b000;
      end else begin
         r_sr <= {r_sr[1:0], i_sig};
      end
   end

   // r_sr[0] may be metastable; only the two later stages feed the detector.
   assign o_rise = (r_sr[2:1] == 2'b01);

endmodule

// File: rtl/freq_meas_scheduler.sv
// ---------------------------------------------------------------------------
// freq_meas_scheduler
// Time-shares one period counter across NCH feedback inputs. Each channel is
// armed in turn, one full rising-to-rising period is counted, and the result
// is written to that channel's register before moving to the next channel.
// A channel that shows no edge within TIMEOUT cycles (in either the arm or
// the measure phase) stores period 0 with valid cleared.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   enable       in   scheduler run enable; dropping it aborts the channel
//   signals      in   NCH asynchronous feedback pins
//   period_flat  out  NCH*CW packed periods, channel i at [i*CW +: CW]
//   valid        out  per-channel result valid
//   upd_stb      out  one-cycle pulse when a channel result is written
//   upd_ch       out  channel written at upd_stb
//   busy         out  high while arming or measuring
// ---------------------------------------------------------------------------
module freq_meas_scheduler
   import freq_meas_pkg::*;
#(
   parameter int NCH     = DEF_NCH,
   parameter int CW      = DEF_CW,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NCH-1:0]            signals,
   output logic [NCH*CW-1:0]         period_flat,
   output logic [NCH-1:0]            valid,
   output logic                      upd_stb,
   output logic [ch_idx_w(NCH)-1:0]  upd_ch,
   output logic                      busy
);

   localparam int               CHW     = ch_idx_w(NCH);
   localparam logic [CW-1:0]    TO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]    CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    CNT_ZRO = {CW{1'b0}};
   localparam logic [CHW-1:0]   CH_LAST = CHW'(NCH - 1);
   localparam logic [CHW-1:0]   CH_ONE  = {{(CHW-1){1'b0}}, 1'b1};
   localparam logic [CHW-1:0]   CH_ZRO  = {CHW{1'b0}};

   logic [NCH-1:0] w_rise;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [CHW-1:0] r_ch;
   logic [CW-1:0]  r_cnt;
   logic [CW-1:0]  w_cnt_nxt;
   logic [CW-1:0]  r_timer;
   logic [CW-1:0]  w_timer_nxt;
   logic [CW-1:0]  r_result;
   logic [CW-1:0]  w_result_nxt;
   logic           r_ok;
   logic           w_ok_nxt;

   logic [CW-1:0]  r_period [NCH];
   logic [NCH-1:0] r_valid;
   logic           r_upd_stb;
   logic [CHW-1:0] r_upd_ch;
   logic           r_busy;

   logic           w_rise_sel;
   logic           w_timeout;

   // Free-running synchronizers: every channel is always tracked so the
   // selected one is settled the moment the scheduler switches to it.
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         freq_sync_edge u_sync (
            .clk    (clk),
            .reset  (reset),
            .i_sig  (signals[gi]),
            .o_rise (w_rise[gi])
         );
         assign period_flat[gi*CW +: CW] = r_period[gi];
      end
   endgenerate

   assign w_rise_sel = w_rise[r_ch];
   assign w_timeout  = (r_timer == TO_LAST);

   // Next-state and shared counter/timer update for the scheduler FSM.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_timer_nxt  = r_timer;
      w_result_nxt = r_result;
      w_ok_nxt     = r_ok;
      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_state_nxt = ST_ARM;
               w_timer_nxt = CNT_ZRO;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (!enable) begin
               w_state_nxt = ST_IDLE;
            end else if (w_rise_sel) begin
               // The arming edge is cycle 0 of the period, so the count
               // starts at 1 on the following cycle.
               w_cnt_nxt   = CNT_ONE;
               w_timer_nxt = CNT_ZRO;
               w_state_nxt = ST_MEASURE;
            end else if (w_timeout) begin
               w_result_nxt = CNT_ZRO;
               w_ok_nxt     = 1'b0;
               w_state_nxt  = ST_STORE;
            end else begin
               w_timer_nxt = r_timer + CNT_ONE;
            end
         end
         ST_MEASURE: begin
            if (!enable) begin
               w_state_nxt = ST_IDLE;
            end else if (w_rise_sel) begin
               // Edge is checked before timeout so a period of exactly
               // TIMEOUT cycles is still a valid measurement.
               w_result_nxt = r_cnt;
               w_ok_nxt     = 1'b1;
               w_state_nxt  = ST_STORE;
            end else if (w_timeout) begin
               w_result_nxt = CNT_ZRO;
               w_ok_nxt     = 1'b0;
               w_state_nxt  = ST_STORE;
            end else begin
               if (r_cnt != CNT_MAX) begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end else begin
                  w_cnt_nxt = r_cnt;
               end
               w_timer_nxt = r_timer + CNT_ONE;
            end
         end
         ST_STORE: begin
            w_timer_nxt = CNT_ZRO;
            if (enable) begin
               w_state_nxt = ST_ARM;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state, shared counter/timer, pending result and channel pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= CNT_ZRO;
         r_timer  <= CNT_ZRO;
         r_result <= CNT_ZRO;
         r_ok     <= 1'b0;
         r_ch     <= CH_ZRO;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_timer  <= w_timer_nxt;
         r_result <= w_result_nxt;
         r_ok     <= w_ok_nxt;
         if (r_state == ST_STORE) begin
            r_ch <= (r_ch == CH_LAST) ? CH_ZRO : (r_ch + CH_ONE);
         end else begin
            r_ch <= r_ch;
         end
      end
   end

   // Result bank, update strobe and busy flag (all registered outputs).
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            r_period[i] <= CNT_ZRO;
         end
         r_valid   <= {NCH{1'b0}};
         r_upd_stb <= 1'b0;
         r_upd_ch  <= CH_ZRO;
         r_busy    <= 1'b0;
      end else begin
         // Busy follows the state being entered so it lines up with ARM/MEASURE.
         r_busy <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_MEASURE);
         if (r_state == ST_STORE) begin
            r_period[r_ch] <= r_result;
            r_valid[r_ch]  <= r_ok;
            r_upd_stb      <= 1'b1;
            r_upd_ch       <= r_ch;
         end else begin
            r_upd_stb      <= 1'b0;
         end
      end
   end

   assign valid   = r_valid;
   assign upd_stb = r_upd_stb;
   assign upd_ch  = r_upd_ch;
   assign busy    = r_busy;

endmodule

// File: doc/freq_meas_scheduler.md
Name: freq_meas_scheduler

Overview:
Time-shares one period-measurement datapath across NCH spindle/encoder feedback inputs in round-robin order. Each input has its own always-running synchronizer. The shared counter measures one full rising-to-rising period on the selected channel, stores the result in that channel's register, then advances to the next channel. Sits between the raw feedback pins and the register file polled by the SPI/Remora data exchange.

Parameters:
NCH, 4, number of measured input channels (2..16)
CW, 16, width of each stored period result
TIMEOUT, 50000, max clk cycles to wait for an edge in either the ARM or MEASURE phase (1..2^CW-1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  scheduler run enable
signals  in  NCH  asynchronous input signals
period_flat  out  NCH*CW  per-channel period in clk cycles; channel i occupies bits [i*CW +: CW]
valid  out  NCH  per-channel result valid
upd_stb  out  1  one-cycle pulse when a channel result is written
upd_ch  out  $clog2(NCH)  channel written at upd_stb
busy  out  1  high while in ARM or MEASURE

Behaviour:
- Reset: period_flat=0, valid=0, upd_stb=0, upd_ch=0, busy=0, current channel=0, state=IDLE. Synchronizer flops are cleared to 0.
- Per-channel 3-flop shift register: sr <= {sr[1:0], signals[i]}. Edge is defined as rise[i] = (sr[2:1]==2'b01). The edge is 2-3 cycles behind the pin.
- States: IDLE, ARM, MEASURE, STORE.
- IDLE: if enable, go to ARM. On entry to ARM, clear timer.
- ARM: waits for rise[ch].
  - On rise[ch]: cnt<=1, timer<=0, go to MEASURE.
  - Else if timer==TIMEOUT-1: result=0, ok=0, go to STORE.
  - Else timer++.
- MEASURE:
  - On rise[ch]: result=cnt, ok=1, go to STORE.
  - Else if timer==TIMEOUT-1: result=0, ok=0, go to STORE.
  - Else cnt++ (saturates at 2^CW-1) and timer++.
  - For a signal with period P clks, result=P.
- Simultaneous edge and timeout in the same cycle: the edge wins.
- STORE (1 cycle):
  - period[ch]<=result, valid[ch]<=ok, upd_stb<=1, upd_ch<=ch.
  - ch<=(ch==NCH-1)?0:ch+1.
  - Next state is ARM if enable, else IDLE.
- Edges on non-selected channels are ignored and not queued.
- A rise[ch] in the first ARM cycle after a channel switch counts. Synchronizers run continuously, so there is no settling gap.
- enable deasserted in ARM or MEASURE: abort immediately to IDLE and discard the partial count. Stored period/valid are retained, and ch is not advanced.
- Reset mid-measurement behaves exactly as power-up reset.
- busy=1 in ARM/MEASURE, 0 in IDLE/STORE. upd_stb is high only in the cycle after STORE is taken (registered).
- Outputs are registered. Results change only on upd_stb cycles or reset.

Decomposition:
- Shared package freq_meas_pkg:
  - state encoding constants (IDLE=0, ARM=1, MEASURE=2, STORE=3)
  - default CW and TIMEOUT
  - channel-index width function
- Sub-module freq_sync_edge: one 3-flop synchronizer plus rising-edge detect per channel, instantiated NCH times by generate.
- Scheduler FSM, shared cnt/timer and the result register bank stay in the top.

Test Plan:
1. Reset, enable=1, ch0 square wave period 100 clks, others held 0, TIMEOUT=1000 -> upd_ch=0 with period 100, valid=1. Then ch1..3 each store period=0, valid=0 about 1000 clks after their ARM entry. Then the cycle wraps to ch0.
2. Channels 0..3 at periods 40, 41, 1000, 7 with TIMEOUT=5000 -> after one rotation period_flat = {7,1000,41,40}, valid=4'hF, and upd_ch sequence is 0,1,2,3,0.
3. ch2 period 1200 with TIMEOUT=1000 -> MEASURE times out, period[2]=0, valid[2]=0, and the previous ch2 value is overwritten.
4. Edge arrives on the exact cycle timer==TIMEOUT-1 (period = TIMEOUT) -> result=TIMEOUT, valid=1.
5. Drop enable mid-MEASURE on ch1 -> state IDLE, busy=0, no upd_stb, period/valid unchanged. Re-enable -> measurement restarts on ch1.
6. Assert reset mid-MEASURE with all valid=1 -> next cycle period_flat=0, valid=0, upd_ch=0, busy=0. Measurement resumes from ch0 when enabled.
